// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_rr_arbiter: 4-channel packet-locking round-robin arbiter + output slice
// Revision: 1.0
// ----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    in_valid,
  input  logic [3:0]    in_last,
  input  logic [BW-1:0] in_data0,
  input  logic [BW-1:0] in_data1,
  input  logic [BW-1:0] in_data2,
  input  logic [BW-1:0] in_data3,
  output logic [3:0]    in_ready,
  output logic          out_valid,
  output logic [BW-1:0] out_data,
  output logic [1:0]    out_sel,
  output logic          out_last,
  input  logic          out_ready
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    lock_ch_q, lock_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [BW-1:0] out_data_q, out_data_d;
  logic [1:0]    out_sel_q, out_sel_d;
  logic          out_last_q, out_last_d;

  logic          load;
  logic          accept;
  logic          grant_vld;
  logic [1:0]    grant;
  logic [1:0]    idx;
  logic [BW-1:0] grant_data;

  // Grant selection: scanning offsets high-to-low lets the nearest valid
  // channel after ptr overwrite any farther candidate.
  always_comb begin
    grant     = ptr_q;
    grant_vld = 1'b0;
    idx       = 2'd0;
    if (state_q == S_LOCK) begin
      grant     = lock_ch_q;
      grant_vld = in_valid[lock_ch_q];
    end else begin
      for (int k = 3; k >= 0; k--) begin
        idx = ptr_q + 2'(k);
        if (in_valid[idx]) grant = idx;
      end
      grant_vld = |in_valid;
    end
  end

  always_comb begin
    case (grant)
      2'd0:    grant_data = in_data0;
      2'd1:    grant_data = in_data1;
      2'd2:    grant_data = in_data2;
      default: grant_data = in_data3;
    endcase
  end

  assign load     = !out_valid_q || out_ready;
  assign accept   = rst_n && load && grant_vld;
  assign in_ready = accept ? (4'b0001 << grant) : 4'b0000;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant;
      out_last_d  = in_last[grant];
      if (in_last[grant]) begin
        state_d = S_IDLE;
        ptr_d   = grant + 2'd1;
      end else begin
        state_d   = S_LOCK;
        lock_ch_d = grant;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      lock_ch_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mux_rr_arbiter: directed + random checks against a packet-level model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [7:0] d [4];
  logic [3:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_last;
  logic       out_ready;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int       m_ptr;
  bit       m_locked;
  int       m_lock;
  bit       m_ov;
  int       m_od;
  int       m_os;
  bit       m_ol;
  logic [3:0] exp_ready;
  logic [3:0] obs_ready;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.BW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data0  (d[0]),
    .in_data1  (d[1]),
    .in_data2  (d[2]),
    .in_data3  (d[3]),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational ready mid-cycle, advance model, check flops.
  task automatic cycle();
    int  g;
    bit  gv;
    bit  acc;
    bit  ld;
    @(negedge clk);
    g  = m_ptr;
    gv = 1'b0;
    if (m_locked) begin
      g  = m_lock;
      gv = in_valid[m_lock];
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!gv && in_valid[(m_ptr + k) % 4]) begin
          g  = (m_ptr + k) % 4;
          gv = 1'b1;
        end
      end
    end
    ld  = !m_ov || out_ready;
    acc = (rst_n === 1'b1) && ld && gv;
    exp_ready = acc ? 4'(1 << g) : 4'b0000;
    obs_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    if (rst_n !== 1'b1) begin
      m_ptr = 0; m_locked = 0; m_lock = 0;
      m_ov = 0; m_od = 0; m_os = 0; m_ol = 0;
    end else if (acc) begin
      m_ov = 1; m_od = int'(d[g]); m_os = g; m_ol = in_last[g];
      if (in_last[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % 4;
      end else begin
        m_locked = 1;
        m_lock   = g;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_sel",  32'(out_sel),  32'(m_os));
      chk("out_last", 32'(out_last), 32'(m_ol));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
    m_ptr = 0; m_locked = 0; m_lock = 0;
    m_ov = 0; m_od = 0; m_os = 0; m_ol = 0;

    // Reset with every channel requesting
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_ready", 32'(obs_ready), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_sel", 32'(out_sel), 32'h0);
    end

    // Round-robin rotation of single-beat packets
    rst_n = 1'b1;
    d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_sel", 32'(out_sel), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'(8'hA0 + (i % 4)));
      chk("rr_valid", 32'(out_valid), 32'h1);
    end

    // Packet lock: channel 1 three beats while channel 2 waits
    in_valid = 4'b0110; in_last = 4'b0100;
    d[1] = 8'h11; cycle(); chk("lock_b1", 32'(obs_ready), 32'h2);
    d[1] = 8'h12; cycle(); chk("lock_b2", 32'(obs_ready), 32'h2);
    d[1] = 8'h13; in_last = 4'b0110; cycle(); chk("lock_b3", 32'(obs_ready), 32'h2);
    in_valid = 4'b0101; d[2] = 8'h20;
    cycle(); chk("lock_next_ch2", 32'(obs_ready), 32'h4);

    // Back-pressure with 0x5C held in the output register
    in_valid = 4'b0001; in_last = 4'b0001; d[0] = 8'h5C;
    cycle();
    out_ready = 1'b0; in_valid = 4'hF; in_last = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_ready", 32'(obs_ready), 32'h0);
      chk("bp_data", 32'(out_data), 32'h5C);
      chk("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_valid", 32'(out_valid), 32'h1);

    // Locked-channel gap on channel 3, then wrap to channel 0
    in_valid = 4'b1000; in_last = 4'b0000; d[3] = 8'h31;
    cycle(); chk("gap_first", 32'(obs_ready), 32'h8);
    in_valid = 4'b0001; in_last = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cycle(); chk("gap_stall", 32'(obs_ready), 32'h0);
    end
    in_valid = 4'b1001; in_last = 4'b1001; d[3] = 8'h33;
    cycle(); chk("gap_last", 32'(obs_ready), 32'h8);
    in_valid = 4'hF;
    cycle(); chk("gap_wrap_ch0", 32'(obs_ready), 32'h1);

    // Reset in the middle of a channel 2 packet
    in_valid = 4'b0100; in_last = 4'b0000; d[2] = 8'h2A;
    cycle(); chk("mid_first", 32'(obs_ready), 32'h4);
    rst_n = 1'b0;
    cycle(); chk("mid_rst_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1; in_valid = 4'b0101;
    cycle(); chk("mid_after_ch0", 32'(obs_ready), 32'h1);

    // Randomized traffic; pending beats hold data/last/valid until taken
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] hold;
      hold = in_valid & ~exp_ready;
      rst_n = ($urandom_range(0, 99) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) begin
        if (!hold[c]) begin
          in_valid[c] = ($urandom_range(0, 2) != 0);
          in_last[c]  = ($urandom_range(0, 2) == 0);
          d[c]        = 8'($urandom);
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
